alu_writeback_stage: RTL

Registered stage directly downstream of the ALU arithmetic datapath. Accepts each combinational result, its zero flag and its destination register index. Buffers them in a 2-entry FIFO and presents them to register-file writeback with a valid/ready handshake. Also keeps the architectural zero flag of the last retired operation and a count of retired operations.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_wb_fifo2.sv | 74 +++++++
 rtl/alu_writeback_stage.sv | 63 ++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU writeback slice.
// Widths, op encodings and the buffered entry layout.
package alu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CNT_W  = 16;

    localparam int DEF_ENTRY_W = DEF_DATA_W + 1 + DEF_ADDR_W;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0010
    } alu_op_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  zero;
        logic [DEF_ADDR_W-1:0] rd;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_fifo2.sv
// Two-entry FIFO with occupancy FSM.
// Head is zeroed while empty so consumers never see stale data.
module alu_wb_fifo2
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_ENTRY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_entry,
    output logic             head_valid,
    input  logic             head_ready,
    output logic [WIDTH-1:0] head_entry
);

    occ_e             occ;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [WIDTH-1:0] mem [2];
    logic             push;
    logic             pop;

    assign in_ready   = (occ != OCC_FULL) && !reset;
    assign head_valid = (occ != OCC_EMPTY);
    assign push       = in_valid && in_ready;
    assign pop        = head_valid && head_ready;
    assign head_entry = head_valid ? mem[rd_ptr] : '0;

    // Entry storage; contents only matter while occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Occupancy state and pointers; reset discards everything buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ    <= OCC_EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            unique case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        occ <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && !pop) begin
                        occ <= OCC_FULL;
                    end else if (pop && !push) begin
                        occ <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        occ <= OCC_ONE;
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Registered writeback stage after the ALU datapath.
// Buffers results and tracks retired count and zero flag.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_zero,
    input  logic [ADDR_W-1:0] in_rd,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_rd,
    output logic              wb_we,
    output logic              zero_flag,
    output logic [CNT_W-1:0]  retired_count
);

    localparam int EW = DATA_W + 1 + ADDR_W;

    logic [EW-1:0] in_entry;
    logic [EW-1:0] head_entry;
    logic          head_zero;
    logic          pop;

    assign in_entry = {in_result, in_zero, in_rd};
    assign {wb_data, head_zero, wb_rd} = head_entry;

    alu_wb_fifo2 #(
        .WIDTH(EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_entry  (in_entry),
        .head_valid(wb_valid),
        .head_ready(wb_ready),
        .head_entry(head_entry)
    );

    assign pop   = wb_valid && wb_ready;
    assign wb_we = wb_valid && (wb_rd != '0);

    // Retire bookkeeping: every pop, x0 writes included, counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_flag     <= 1'b0;
            retired_count <= '0;
        end else if (pop) begin
            zero_flag     <= head_zero;
            retired_count <= retired_count + CNT_W'(1);
        end
    end

endmodule
